// File: rtl/servo_waypoint_sequencer.sv
// servo_waypoint_sequencer
// Walks one servo speed-control channel through a table of waypoints
// {target position, ramp speed, dwell cycles}. For each entry it loads the
// controller command registers, pulses go for one cycle, waits for the
// controller's rdy, then holds for the dwell time before the next entry.
//
// Optional build macro: SEQ_LOOP_EN
//   Adds input i_loop (sampled on start). With i_loop=1 the table repeats
//   from entry 0 after the last dwell and only abort ends the sequence.
//
// Controller handshake (go/rdy): o_srv_go is a registered single-cycle
// pulse; the controller captures start/end/speed on the clock edge that
// ends the go cycle. i_srv_rdy is only trusted from the cycle after go
// (MOVE onwards), when it reflects the newly loaded command. There is no
// back-pressure on go; rdy is level-sensitive and is sampled once per
// MOVE cycle.
module servo_waypoint_sequencer #(
  parameter int CNTR_BITS  = 16,
  parameter int IDX_BITS   = 3,
  parameter int DWELL_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [IDX_BITS-1:0]   i_wr_addr,
  input  logic [CNTR_BITS-1:0]  i_wr_pos,
  input  logic [CNTR_BITS-1:0]  i_wr_speed,
  input  logic [DWELL_BITS-1:0] i_wr_dwell,
  input  logic [IDX_BITS:0]     i_num_pts,
  input  logic                  i_start,
  input  logic                  i_abort,
`ifdef SEQ_LOOP_EN
  input  logic                  i_loop,
`endif
  input  logic [CNTR_BITS-1:0]  i_srv_pos,
  input  logic                  i_srv_rdy,
  output logic [CNTR_BITS-1:0]  o_srv_start_pos,
  output logic [CNTR_BITS-1:0]  o_srv_end_pos,
  output logic [CNTR_BITS-1:0]  o_srv_speed,
  output logic                  o_srv_go,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [IDX_BITS-1:0]   o_cur_idx,
  output logic [2:0]            o_state
);

  localparam int DEPTH = 1 << IDX_BITS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_GO    = 3'd2;
  localparam logic [2:0] S_MOVE  = 3'd3;
  localparam logic [2:0] S_DWELL = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  // Waypoint table; contents are undefined until written.
  logic [CNTR_BITS-1:0]  r_tbl_pos   [DEPTH];
  logic [CNTR_BITS-1:0]  r_tbl_speed [DEPTH];
  logic [DWELL_BITS-1:0] r_tbl_dwell [DEPTH];

  logic [2:0]            r_state;
  logic [IDX_BITS-1:0]   r_idx;
  logic [IDX_BITS:0]     r_num;
  logic [DWELL_BITS-1:0] r_dwell_cnt;
  logic [CNTR_BITS-1:0]  r_start_pos;
  logic [CNTR_BITS-1:0]  r_end_pos;
  logic [CNTR_BITS-1:0]  r_speed;
  logic                  r_go;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_last;
  logic                  w_loop;
  logic                  w_start_ok;
  logic [CNTR_BITS-1:0]  w_tbl_speed;

  // A real sequence start: idle, start pulse, abort not competing.
  assign w_start_ok = (r_state == S_IDLE) && i_start && !i_abort;

  // Active entry is the last one to run this pass.
  assign w_last = ({1'b0, r_idx} == (r_num - (IDX_BITS+1)'(1)));

  // Speed 0 would never reach the target, so it is promoted to 1.
  assign w_tbl_speed = (r_tbl_speed[r_idx] == '0) ? CNTR_BITS'(1) : r_tbl_speed[r_idx];

`ifdef SEQ_LOOP_EN
  logic r_loop;

  // Loop mode is captured once per sequence start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_loop <= 1'b0;
    end else if (w_start_ok && (i_num_pts != '0)) begin
      r_loop <= i_loop;
    end
  end

  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  // Table writes are accepted only while no sequence is running.
  always_ff @(posedge clk) begin
    if (i_wr_en && !r_busy) begin
      r_tbl_pos[i_wr_addr]   <= i_wr_pos;
      r_tbl_speed[i_wr_addr] <= i_wr_speed;
      r_tbl_dwell[i_wr_addr] <= i_wr_dwell;
    end
  end

  // Sequencer FSM; abort outranks every other transition outside IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_num       <= '0;
      r_dwell_cnt <= '0;
      r_start_pos <= '0;
      r_end_pos   <= '0;
      r_speed     <= '0;
      r_go        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_go   <= 1'b0;
      r_done <= 1'b0;
      if ((r_state != S_IDLE) && i_abort) begin
        // Freeze: command a zero-length move at the present position.
        r_state     <= S_STOP;
        r_start_pos <= i_srv_pos;
        r_end_pos   <= i_srv_pos;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_ok) begin
              if (i_num_pts == '0) begin
                r_done <= 1'b1;
              end else begin
                r_num   <= i_num_pts;
                r_idx   <= '0;
                r_busy  <= 1'b1;
                r_state <= S_LOAD;
              end
            end
          end
          S_LOAD: begin
            // Start from where the servo is now so there is no jump.
            r_start_pos <= i_srv_pos;
            r_end_pos   <= r_tbl_pos[r_idx];
            r_speed     <= w_tbl_speed;
            r_go        <= 1'b1;
            r_state     <= S_GO;
          end
          S_GO: begin
            r_state <= S_MOVE;
          end
          S_MOVE: begin
            if (i_srv_rdy) begin
              r_dwell_cnt <= r_tbl_dwell[r_idx];
              r_state     <= S_DWELL;
            end
          end
          S_DWELL: begin
            if (r_dwell_cnt == '0) begin
              if (w_last && !w_loop) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end else if (w_last) begin
                r_idx   <= '0;
                r_state <= S_LOAD;
              end else begin
                r_idx   <= r_idx + 1'b1;
                r_state <= S_LOAD;
              end
            end else begin
              r_dwell_cnt <= r_dwell_cnt - 1'b1;
            end
          end
          S_STOP: begin
            // Issue the freezing go; the sequence is over from here.
            r_go    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_srv_start_pos = r_start_pos;
  assign o_srv_end_pos   = r_end_pos;
  assign o_srv_speed     = r_speed;
  assign o_srv_go        = r_go;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_cur_idx       = r_idx;
  assign o_state         = r_state;

endmodule

// File: tb/tb_servo_waypoint_sequencer.sv
// Directed bench for servo_waypoint_sequencer with a simple ramping
// speed-controller model closing the go/rdy loop.
module tb_servo_waypoint_sequencer;

  localparam int CB = 16;
  localparam int IB = 3;
  localparam int DB = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          i_wr_en = 1'b0;
  logic [IB-1:0] i_wr_addr = '0;
  logic [CB-1:0] i_wr_pos = '0;
  logic [CB-1:0] i_wr_speed = '0;
  logic [DB-1:0] i_wr_dwell = '0;
  logic [IB:0]   i_num_pts = '0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
`ifdef SEQ_LOOP_EN
  logic          i_loop = 1'b0;
`endif
  logic [CB-1:0] i_srv_pos;
  logic          i_srv_rdy;
  logic [CB-1:0] o_srv_start_pos, o_srv_end_pos, o_srv_speed;
  logic          o_srv_go, o_busy, o_done;
  logic [IB-1:0] o_cur_idx;
  logic [2:0]    o_state;

  servo_waypoint_sequencer #(.CNTR_BITS(CB), .IDX_BITS(IB), .DWELL_BITS(DB)) dut (
    .clk(clk), .rst(rst),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_pos(i_wr_pos),
    .i_wr_speed(i_wr_speed), .i_wr_dwell(i_wr_dwell),
    .i_num_pts(i_num_pts), .i_start(i_start), .i_abort(i_abort),
`ifdef SEQ_LOOP_EN
    .i_loop(i_loop),
`endif
    .i_srv_pos(i_srv_pos), .i_srv_rdy(i_srv_rdy),
    .o_srv_start_pos(o_srv_start_pos), .o_srv_end_pos(o_srv_end_pos),
    .o_srv_speed(o_srv_speed), .o_srv_go(o_srv_go), .o_busy(o_busy),
    .o_done(o_done), .o_cur_idx(o_cur_idx), .o_state(o_state)
  );

  // ---------------- speed controller model ----------------
  // Loads command on the go edge, then steps toward end_pos by speed.
  logic [CB-1:0] m_pos = '0;
  logic [CB-1:0] m_end = '0;
  logic [CB-1:0] m_spd = 16'd1;
  always @(posedge clk) begin
    if (o_srv_go) begin
      m_pos <= o_srv_start_pos;
      m_end <= o_srv_end_pos;
      m_spd <= o_srv_speed;
    end else if (m_pos < m_end) begin
      m_pos <= ((m_end - m_pos) > m_spd) ? m_pos + m_spd : m_end;
    end else if (m_pos > m_end) begin
      m_pos <= ((m_pos - m_end) > m_spd) ? m_pos - m_spd : m_end;
    end
  end
  assign i_srv_pos = m_pos;
  assign i_srv_rdy = (m_pos == m_end);

  // ---------------- observation monitor ----------------
  logic [CB-1:0] obs_start_q[$];
  logic [CB-1:0] obs_end_q[$];
  logic [CB-1:0] obs_spd_q[$];
  logic [IB-1:0] obs_idx_q[$];
  int            obs_cyc_q[$];
  int            done_cnt = 0;
  always @(negedge clk) begin
    if (o_srv_go) begin
      obs_start_q.push_back(o_srv_start_pos);
      obs_end_q.push_back(o_srv_end_pos);
      obs_spd_q.push_back(o_srv_speed);
      obs_idx_q.push_back(o_cur_idx);
      obs_cyc_q.push_back(cyc);
    end
    if (o_done) done_cnt = done_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [CB-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // ---------------- driver tasks ----------------
  task automatic write_entry(input int a, input int p, input int s, input int d);
    i_wr_en = 1'b1; i_wr_addr = IB'(a); i_wr_pos = CB'(p);
    i_wr_speed = CB'(s); i_wr_dwell = DB'(d);
    @(posedge clk); #1;
    i_wr_en = 1'b0;
  endtask

  task automatic start_run(input int n, output int s);
    i_start = 1'b1; i_num_pts = (IB+1)'(n);
    @(posedge clk); #1;
    s = cyc;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit seen, output int at, output logic b);
    seen = 1'b0; at = 0; b = 1'bx;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (o_done) begin seen = 1'b1; at = cyc; b = o_busy; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic home_to_zero();
    int s, at; bit seen; logic b;
    write_entry(0, 0, 16'hFFFF, 0);
    start_run(1, s);
    wait_done(100, seen, at, b);
    n_checks++;
    if (seen !== 1'b1) begin n_errors++; $display("FAIL home_timeout: done=%0d required 1", seen); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (o_state !== 3'd0) begin n_errors++; $display("FAIL rst_state: got %0d required 0", o_state); end
    n_checks++; if (o_srv_go !== 1'b0) begin n_errors++; $display("FAIL rst_go: got %0d required 0", o_srv_go); end
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %0d required 0", o_busy); end
    n_checks++; if (o_done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %0d required 0", o_done); end
    n_checks++; if (o_cur_idx !== '0) begin n_errors++; $display("FAIL rst_idx: got %0d required 0", o_cur_idx); end
    n_checks++; if (o_srv_start_pos !== '0) begin n_errors++; $display("FAIL rst_start: got %0d required 0", o_srv_start_pos); end
    n_checks++; if (o_srv_end_pos !== '0) begin n_errors++; $display("FAIL rst_end: got %0d required 0", o_srv_end_pos); end
    n_checks++; if (o_srv_speed !== '0) begin n_errors++; $display("FAIL rst_speed: got %0d required 0", o_srv_speed); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_two_points();
    int s, at, n0, d0; bit seen; logic b;
    write_entry(0, 1000, 100, 5);
    write_entry(1, 400, 50, 0);
    n0 = obs_end_q.size(); d0 = done_cnt;
    start_run(2, s);
    wait_done(100, seen, at, b);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL two_done_seen: got %0d required 1", seen); end
    n_checks++; if (at - s !== 35) begin n_errors++; $display("FAIL two_done_latency: got %0d required 35", at - s); end
    n_checks++; if (b !== 1'b0) begin n_errors++; $display("FAIL two_busy_at_done: got %0d required 0", b); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_errors++; $display("FAIL two_done_count: got %0d required 1", done_cnt - d0); end
    n_checks++; if (obs_end_q.size() - n0 !== 2) begin n_errors++; $display("FAIL two_go_count: got %0d required 2", obs_end_q.size() - n0); end
    if (obs_end_q.size() - n0 == 2) begin
      exp_q.delete(); exp_q.push_back(16'd1000); exp_q.push_back(16'd400);
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (obs_end_q[n0+i] !== exp_q[i]) begin n_errors++; $display("FAIL two_end_pos[%0d]: got %0d required %0d", i, obs_end_q[n0+i], exp_q[i]); end
        n_checks++; if (obs_idx_q[n0+i] !== IB'(i)) begin n_errors++; $display("FAIL two_cur_idx[%0d]: got %0d required %0d", i, obs_idx_q[n0+i], i); end
      end
      n_checks++; if (obs_start_q[n0] !== 16'd0) begin n_errors++; $display("FAIL two_start0: got %0d required 0", obs_start_q[n0]); end
      n_checks++; if (obs_start_q[n0+1] !== 16'd1000) begin n_errors++; $display("FAIL two_start1: got %0d required 1000", obs_start_q[n0+1]); end
      n_checks++; if (obs_spd_q[n0] !== 16'd100) begin n_errors++; $display("FAIL two_speed0: got %0d required 100", obs_spd_q[n0]); end
      n_checks++; if (obs_spd_q[n0+1] !== 16'd50) begin n_errors++; $display("FAIL two_speed1: got %0d required 50", obs_spd_q[n0+1]); end
      n_checks++; if (obs_cyc_q[n0] - s !== 1) begin n_errors++; $display("FAIL two_go0_cycle: got %0d required 1", obs_cyc_q[n0] - s); end
      n_checks++; if (obs_cyc_q[n0+1] - s !== 20) begin n_errors++; $display("FAIL two_go1_cycle: got %0d required 20", obs_cyc_q[n0+1] - s); end
    end
  endtask

  task automatic test_zero_pts();
    int n0, d0;
    n0 = obs_end_q.size(); d0 = done_cnt;
    i_start = 1'b1; i_num_pts = '0;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    n_checks++; if (o_done !== 1'b1) begin n_errors++; $display("FAIL zero_done_pulse: got %0d required 1", o_done); end
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL zero_busy: got %0d required 0", o_busy); end
    @(negedge clk);
    n_checks++; if (o_done !== 1'b0) begin n_errors++; $display("FAIL zero_done_width: got %0d required 0", o_done); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (obs_end_q.size() - n0 !== 0) begin n_errors++; $display("FAIL zero_no_go: got %0d required 0", obs_end_q.size() - n0); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_errors++; $display("FAIL zero_done_count: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_speed_zero();
    int s, at, n0; bit seen; logic b;
    home_to_zero();
    write_entry(0, 10, 0, 0);
    n0 = obs_end_q.size();
    start_run(1, s);
    wait_done(60, seen, at, b);
    n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL spd0_done_seen: got %0d required 1", seen); end
    n_checks++; if (at - s !== 14) begin n_errors++; $display("FAIL spd0_latency: got %0d required 14", at - s); end
    n_checks++; if (obs_end_q.size() - n0 !== 1) begin n_errors++; $display("FAIL spd0_go_count: got %0d required 1", obs_end_q.size() - n0); end
    if (obs_end_q.size() - n0 == 1) begin
      n_checks++; if (obs_spd_q[n0] !== 16'd1) begin n_errors++; $display("FAIL spd0_speed: got %0d required 1", obs_spd_q[n0]); end
      n_checks++; if (obs_end_q[n0] !== 16'd10) begin n_errors++; $display("FAIL spd0_end: got %0d required 10", obs_end_q[n0]); end
    end
  endtask

  task automatic test_abort();
    int s, n0, d0;
    home_to_zero();
    write_entry(0, 1000, 100, 5);
    write_entry(1, 400, 50, 0);
    n0 = obs_end_q.size(); d0 = done_cnt;
    start_run(2, s);
    repeat (7) @(posedge clk); #1;
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    @(negedge clk);
    n_checks++; if (o_state !== 3'd5) begin n_errors++; $display("FAIL abort_stop_state: got %0d required 5", o_state); end
    n_checks++; if (o_srv_go !== 1'b0) begin n_errors++; $display("FAIL abort_stop_go: got %0d required 0", o_srv_go); end
    n_checks++; if (o_srv_start_pos !== 16'd500) begin n_errors++; $display("FAIL abort_start_pos: got %0d required 500", o_srv_start_pos); end
    n_checks++; if (o_srv_end_pos !== 16'd500) begin n_errors++; $display("FAIL abort_end_pos: got %0d required 500", o_srv_end_pos); end
    @(negedge clk);
    n_checks++; if (o_srv_go !== 1'b1) begin n_errors++; $display("FAIL abort_go_pulse: got %0d required 1", o_srv_go); end
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %0d required 0", o_busy); end
    repeat (20) @(posedge clk); #1;
    n_checks++; if (done_cnt - d0 !== 0) begin n_errors++; $display("FAIL abort_no_done: got %0d required 0", done_cnt - d0); end
    n_checks++; if (obs_end_q.size() - n0 !== 2) begin n_errors++; $display("FAIL abort_go_count: got %0d required 2", obs_end_q.size() - n0); end
    n_checks++; if (o_state !== 3'd0) begin n_errors++; $display("FAIL abort_idle: got %0d required 0", o_state); end
    n_checks++; if (i_srv_pos !== 16'd500) begin n_errors++; $display("FAIL abort_frozen_pos: got %0d required 500", i_srv_pos); end
  endtask

  task automatic test_busy_ignore();
    int s, at, n0, d0; bit seen; logic b;
    write_entry(0, 1000, 100, 5);
    n0 = obs_end_q.size(); d0 = done_cnt;
    start_run(1, s);
    repeat (3) @(posedge clk); #1;
    write_entry(0, 9999, 7, 7);
    i_start = 1'b1; i_num_pts = 4'd2;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done(100, seen, at, b);
    repeat (3) @(posedge clk); #1;
    n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL busy_done_seen: got %0d required 1", seen); end
    n_checks++; if (obs_end_q.size() - n0 !== 1) begin n_errors++; $display("FAIL busy_start_ignored: got %0d required 1", obs_end_q.size() - n0); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_errors++; $display("FAIL busy_done_count: got %0d required 1", done_cnt - d0); end
    n0 = obs_end_q.size();
    start_run(1, s);
    wait_done(100, seen, at, b);
    n_checks++; if (obs_end_q.size() - n0 !== 1) begin n_errors++; $display("FAIL busy_rerun_go_count: got %0d required 1", obs_end_q.size() - n0); end
    if (obs_end_q.size() - n0 == 1) begin
      n_checks++; if (obs_end_q[n0] !== 16'd1000) begin n_errors++; $display("FAIL busy_write_ignored: got %0d required 1000", obs_end_q[n0]); end
      n_checks++; if (obs_spd_q[n0] !== 16'd100) begin n_errors++; $display("FAIL busy_speed_kept: got %0d required 100", obs_spd_q[n0]); end
    end
  endtask

  task automatic test_start_abort_idle();
    int n0, d0;
    n0 = obs_end_q.size(); d0 = done_cnt;
    i_start = 1'b1; i_abort = 1'b1; i_num_pts = 4'd1;
    @(posedge clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
    @(negedge clk);
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL sa_busy: got %0d required 0", o_busy); end
    n_checks++; if (o_state !== 3'd0) begin n_errors++; $display("FAIL sa_state: got %0d required 0", o_state); end
    repeat (5) @(posedge clk); #1;
    n_checks++; if (obs_end_q.size() - n0 !== 0) begin n_errors++; $display("FAIL sa_no_go: got %0d required 0", obs_end_q.size() - n0); end
    n_checks++; if (done_cnt - d0 !== 0) begin n_errors++; $display("FAIL sa_no_done: got %0d required 0", done_cnt - d0); end
  endtask

  task automatic test_rst_mid();
    int s; bit seen;
    write_entry(0, 300, 100, 20);
    start_run(1, s);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_state == 3'd4) begin seen = 1'b1; break; end
    end
    n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL rstmid_dwell_reached: got %0d required 1", seen); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %0d required 0", o_busy); end
    n_checks++; if (o_state !== 3'd0) begin n_errors++; $display("FAIL rstmid_state: got %0d required 0", o_state); end
    n_checks++; if (o_srv_start_pos !== '0) begin n_errors++; $display("FAIL rstmid_start: got %0d required 0", o_srv_start_pos); end
    n_checks++; if (o_srv_end_pos !== '0) begin n_errors++; $display("FAIL rstmid_end: got %0d required 0", o_srv_end_pos); end
    n_checks++; if (o_srv_speed !== '0) begin n_errors++; $display("FAIL rstmid_speed: got %0d required 0", o_srv_speed); end
    n_checks++; if (o_srv_go !== 1'b0) begin n_errors++; $display("FAIL rstmid_go: got %0d required 0", o_srv_go); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    int s, n0, d0; bit seen;
    write_entry(0, 100, 100, 0);
    write_entry(1, 0, 100, 0);
    n0 = obs_end_q.size(); d0 = done_cnt;
    i_loop = 1'b1;
    start_run(2, s);
    i_loop = 1'b0;
    for (int i = 0; i < 200 && obs_end_q.size() < n0 + 4; i++) @(negedge clk);
    @(posedge clk); #1;
    n_checks++; if (obs_end_q.size() < n0 + 4) begin n_errors++; $display("FAIL loop_go_count: got %0d required 4", obs_end_q.size() - n0); end
    if (obs_end_q.size() >= n0 + 4) begin
      exp_q.delete();
      exp_q.push_back(16'd100); exp_q.push_back(16'd0); exp_q.push_back(16'd100); exp_q.push_back(16'd0);
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (obs_idx_q[n0+i] !== IB'(i % 2)) begin n_errors++; $display("FAIL loop_idx[%0d]: got %0d required %0d", i, obs_idx_q[n0+i], i % 2); end
        n_checks++; if (obs_end_q[n0+i] !== exp_q[i]) begin n_errors++; $display("FAIL loop_end[%0d]: got %0d required %0d", i, obs_end_q[n0+i], exp_q[i]); end
      end
    end
    n_checks++; if (done_cnt - d0 !== 0) begin n_errors++; $display("FAIL loop_no_done: got %0d required 0", done_cnt - d0); end
    n_checks++; if (o_busy !== 1'b1) begin n_errors++; $display("FAIL loop_busy: got %0d required 1", o_busy); end
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL loop_abort_busy: got %0d required 0", o_busy); end
    n_checks++; if (done_cnt - d0 !== 0) begin n_errors++; $display("FAIL loop_abort_no_done: got %0d required 0", done_cnt - d0); end
    i_loop = 1'b1;
    start_run(2, s);
    i_loop = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_state == 3'd4) begin seen = 1'b1; break; end
    end
    n_checks++; if (seen !== 1'b1) begin n_errors++; $display("FAIL loop_dwell_reached: got %0d required 1", seen); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL loop_rst_busy: got %0d required 0", o_busy); end
    n_checks++; if (o_cur_idx !== '0) begin n_errors++; $display("FAIL loop_rst_idx: got %0d required 0", o_cur_idx); end
    n_checks++; if (o_srv_speed !== '0) begin n_errors++; $display("FAIL loop_rst_speed: got %0d required 0", o_srv_speed); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_two_points();
    test_zero_pts();
    test_speed_zero();
    test_abort();
    test_busy_ignore();
    test_start_abort_idle();
    test_rst_mid();
`ifdef SEQ_LOOP_EN
    test_loop();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/servo_waypoint_sequencer.md
Name: servo_waypoint_sequencer

Overview:
Sequences one servo speed-control channel through a programmable table of waypoints (target position, ramp speed, dwell time). For each waypoint it issues a single-cycle go to the speed controller and waits for its rdy. It then holds the position for the dwell time before moving to the next entry. It sits between the host/config register block and the speed controller feeding the PWM compare.

Parameters:
CNTR_BITS, 16, width of position/speed values (matches speed controller)
IDX_BITS, 3, waypoint index width; table depth = 2**IDX_BITS
DWELL_BITS, 16, width of per-waypoint dwell counter (clk cycles)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wr_en  in  1  table write strobe; ignored while busy
wr_addr  in  IDX_BITS  table entry to write
wr_pos  in  CNTR_BITS  target position for entry
wr_speed  in  CNTR_BITS  ramp step per clk for entry
wr_dwell  in  DWELL_BITS  hold cycles after arrival
num_pts  in  IDX_BITS+1  number of entries to run (0..2**IDX_BITS), sampled on start
start  in  1  start pulse; ignored while busy
abort  in  1  stop sequence, freeze servo at present position
srv_pos  in  CNTR_BITS  speed controller out_cmp (current position)
srv_rdy  in  1  speed controller rdy
srv_start_pos  out  CNTR_BITS  to controller start_pos
srv_end_pos  out  CNTR_BITS  to controller end_pos
srv_speed  out  CNTR_BITS  to controller speed
srv_go  out  1  to controller go, single-cycle, registered
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when sequence completes normally
cur_idx  out  IDX_BITS  index of active waypoint

Behaviour:
- Reset: state IDLE; srv_go=0, busy=0, done=0, cur_idx=0, srv_start_pos=srv_end_pos=srv_speed=0. Table contents are not reset (undefined until written).
- Table: 2**IDX_BITS entries {pos, speed, dwell}. Write occurs on the clk edge with wr_en=1 and busy=0. A write to an existing address overwrites it.
- States: IDLE, LOAD, GO, MOVE, DWELL, STOP.
- IDLE: on start with num_pts=0, done pulses the next cycle and the block stays IDLE. On start with num_pts>0, latch num_pts, cur_idx<=0, busy<=1, then go to LOAD.
- LOAD: read table[cur_idx] into the output registers.
  - srv_start_pos<=srv_pos, so there is no position jump.
  - srv_end_pos<=pos.
  - srv_speed<=speed, except speed 0 is substituted with 1 so rdy is always reachable.
  - Next state GO.
- GO: srv_go=1 for exactly this cycle. Next state MOVE.
- MOVE: srv_rdy is sampled from the first cycle after GO. The controller's rdy is valid then because it loaded on the GO edge. When srv_rdy=1, load dwell counter=dwell and go to DWELL.
- DWELL: counter decrements once per cycle.
  - Leave DWELL in the cycle the counter reads 0; dwell=0 therefore gives one DWELL cycle.
  - If cur_idx==num_pts-1, busy<=0, done pulses for one cycle, and the block returns to IDLE.
  - Otherwise cur_idx increments and the block goes to LOAD.
- Move latency per waypoint: LOAD→GO→MOVE is 2 cycles before the ramp, plus the ramp cycles, plus dwell+1.
- abort in any non-IDLE state takes priority over all transitions.
  - Next cycle: STOP, with srv_start_pos=srv_end_pos=srv_pos.
  - The cycle after: GO-style srv_go pulse, which freezes the servo; then IDLE with busy=0.
  - done is not pulsed on abort. abort in IDLE has no effect.
- start and abort in the same cycle while IDLE: abort wins, start is ignored.
- rst mid-sequence: immediate return to reset values, and srv_go is deasserted on the next edge. The speed controller keeps its last command.
- Targets equal to the current position are valid: rdy is high right after GO and MOVE lasts 1 cycle.
- All position/speed arithmetic is done inside the speed controller; the sequencer does no arithmetic except the dwell counter (unsigned, no wrap) and the index increment (IDX_BITS+1 compare against num_pts).

Optional Feature:
SEQ_LOOP_EN:
- Defined: adds input port loop (1 bit, sampled on start). With loop=1, after the last waypoint's dwell the block sets cur_idx<=0 and goes to LOAD instead of finishing. done is not pulsed; only abort ends the sequence. With loop=0, behaviour is identical to the undefined case.
- Undefined: no loop port; the sequence always runs once and ends with done.

Test Plan:
- Write entries 0:{pos=1000,spd=100,dwell=5}, 1:{pos=400,spd=50,dwell=0}; srv_pos=0; start with num_pts=2.
  - srv_go pulses twice, with end_pos 1000 then 400.
  - start_pos of the second go equals 1000.
  - done pulses once; busy falls in the same cycle.
- Start with num_pts=0 -> no srv_go, done high exactly one cycle after start, busy stays 0.
- Entry with speed=0, pos=10, from 0 -> srv_speed driven as 1; srv_rdy reached after 10 ramp cycles; sequence completes.
- abort during MOVE of entry 0 (srv_pos=500 at abort):
  - srv_go pulses with start_pos=end_pos=500.
  - busy=0 afterwards; no done pulse.
- wr_en to entry 0 while busy (new pos=9999) -> ignored; the next run still targets the original value. start while busy -> ignored.
- SEQ_LOOP_EN defined, loop=1, num_pts=2 -> cur_idx sequence 0,1,0,1...; no done; abort terminates; rst mid-DWELL returns all outputs to 0.
